// File: rtl/fm_modulator_if.sv
// Sample-stream bundle between an audio source and the FM modulator.
// No latency of its own; it only carries wires.
// No backpressure: the source drives en/audio_valid and the sink never stalls.
interface fm_modulator_if #(
  parameter int IN_W    = 32,
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 16
);
  logic                      en;
  logic signed [IN_W-1:0]    audio_in;
  logic                      audio_valid;
  logic        [PHASE_W-1:0] carrier_ftw;
  logic signed [OUT_W-1:0]   fm_out;
  logic                      out_valid;

  modport master (
    output en, audio_in, audio_valid, carrier_ftw,
    input  fm_out, out_valid
  );

  modport slave (
    input  en, audio_in, audio_valid, carrier_ftw,
    output fm_out, out_valid
  );
endinterface

// File: rtl/fm_modulator.sv
// NCO FM transmitter: ftw = carrier + (audio >>> DEV_SHIFT), phase acc -> quarter-wave sine ROM.
// Latency: en at edge k -> out_valid pulse and fm_out after edge k+2; 1 sample/clk throughput.
// No backpressure: en bubbles hold phase and fm_out. Optional phase dither via FM_MOD_DITHER_EN.
module fm_modulator #(
  parameter int IN_W      = 32,
  parameter int PHASE_W   = 32,
  parameter int LUT_AW    = 10,
  parameter int OUT_W     = 16,
  parameter int DEV_SHIFT = 8
) (
  input logic           clk,
  input logic           rst,
  fm_modulator_if.slave bus
);

  localparam int ROM_N = 2 ** LUT_AW;
  localparam int LOW_W = PHASE_W - 2 - LUT_AW;

  // Positive quarter-wave table sampled at half-LSB offsets so the mirror is exact.
  function automatic logic [OUT_W-2:0] rom_entry(input int k);
    real amp;
    real ang;
    amp = real'((2 ** (OUT_W - 1)) - 1);
    ang = (3.14159265358979323846 / 2.0) * (real'(k) + 0.5) / real'(ROM_N);
    return (OUT_W - 1)'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  logic [OUT_W-2:0] rom [ROM_N];

  for (genvar k = 0; k < ROM_N; k++) begin : g_rom
    localparam logic [OUT_W-2:0] ENTRY = rom_entry(k);
    assign rom[k] = ENTRY;
  end

  logic signed [IN_W-1:0]    audio_hold;
  logic signed [IN_W-1:0]    audio_dev;
  logic        [PHASE_W-1:0] ftw;
  logic        [PHASE_W-1:0] phase_acc;
  logic        [LUT_AW+1:0]  dec_top;

  // Deviation term is sign-extended so negative audio lowers the frequency.
  assign audio_dev = audio_hold >>> DEV_SHIFT;
  assign ftw       = bus.carrier_ftw + PHASE_W'(audio_dev);

`ifdef FM_MOD_DITHER_EN
  logic [15:0]      lfsr;
  logic             lfsr_fb;
  logic [LOW_W-1:0] dec_unused_lo;

  assign lfsr_fb = lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3];

  // Dither source advances once per emitted sample.
  always_ff @(posedge clk) begin
    if (rst)         lfsr <= 16'hACE1;
    else if (bus.en) lfsr <= {lfsr[14:0], lfsr_fb};
  end

  // Dither lands below the ROM index; only its carry can reach the decoded bits.
  assign {dec_top, dec_unused_lo} = phase_acc + PHASE_W'(lfsr);
`else
  assign dec_top = phase_acc[PHASE_W-1 -: LUT_AW+2];
`endif

  logic [1:0]        quad;
  logic [LUT_AW-1:0] idx;
  logic [LUT_AW-1:0] addr;

  // Odd quadrants walk the table backwards; upper half-cycle negates.
  assign quad = dec_top[LUT_AW+1 -: 2];
  assign idx  = dec_top[LUT_AW-1:0];
  assign addr = quad[0] ? ~idx : idx;

  // Audio hold register, loaded whenever a new sample is offered, independent of en.
  always_ff @(posedge clk) begin
    if (rst)                  audio_hold <= '0;
    else if (bus.audio_valid) audio_hold <= bus.audio_in;
  end

  // Phase accumulator steps by the current tuning word on each sample strobe.
  always_ff @(posedge clk) begin
    if (rst)         phase_acc <= '0;
    else if (bus.en) phase_acc <= phase_acc + ftw;
  end

  logic              a_vld;
  logic              a_neg;
  logic [LUT_AW-1:0] a_addr;
  logic              b_vld;
  logic              b_neg;
  logic [OUT_W-2:0]  b_rom;
  logic [OUT_W-1:0]  b_mag;

  // Stage A: capture the decoded pre-update phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_vld  <= 1'b0;
      a_neg  <= 1'b0;
      a_addr <= '0;
    end else begin
      a_vld <= bus.en;
      if (bus.en) begin
        a_addr <= addr;
        a_neg  <= quad[1];
      end
    end
  end

  // Stage B: table lookup, sign travels alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_vld <= 1'b0;
      b_neg <= 1'b0;
      b_rom <= '0;
    end else begin
      b_vld <= a_vld;
      if (a_vld) begin
        b_rom <= rom[a_addr];
        b_neg <= a_neg;
      end
    end
  end

  assign b_mag = {1'b0, b_rom};

  // Stage C: apply sign; output holds through bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.fm_out    <= '0;
    end else begin
      bus.out_valid <= b_vld;
      if (b_vld) bus.fm_out <= b_neg ? -b_mag : b_mag;
    end
  end

endmodule

// File: tb/tb_fm_modulator.sv
// Self-checking bench for fm_modulator against a sine-of-phase reference model.
// Model predicts each output from the ideal phase sequence and a due-cycle queue.
// Directed tone/deviation/gap/reset scenarios followed by random traffic.
module tb_fm_modulator;
  localparam int  IN_W      = 32;
  localparam int  PHASE_W   = 32;
  localparam int  LUT_AW    = 10;
  localparam int  OUT_W     = 16;
  localparam int  DEV_SHIFT = 8;
  localparam real PI        = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fm_modulator_if #(.IN_W(IN_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W)) bus ();

  fm_modulator #(
    .IN_W(IN_W), .PHASE_W(PHASE_W), .LUT_AW(LUT_AW),
    .OUT_W(OUT_W), .DEV_SHIFT(DEV_SHIFT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int due;
    int val;
  } exp_t;

  int       n_checks = 0;
  int       n_pass   = 0;
  int       cyc      = 0;
  bit [31:0] m_phase = '0;
  int       m_hold   = 0;
  int       m_last   = 0;
  exp_t     m_q[$];
  int       tone[4]  = '{25, 32767, -25, -32767};
  bit       tone_on  = 1'b0;
  int       tone_idx = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Ideal sample: sine at the centre of the 4096-segment phase bin, rounded symmetrically.
  function automatic int ref_sample(input bit [31:0] p);
    int unsigned seg;
    real ang;
    real s;
    seg = p >> 20;
    ang = 2.0 * PI * (real'(seg) + 0.5) / 4096.0;
    s   = 32767.0 * $sin(ang);
    if (s < 0.0) return -$rtoi(-s + 0.5);
    return $rtoi(s + 0.5);
  endfunction

  task automatic model_edge(input bit r, input bit e, input bit av, input int aud,
                            input bit [31:0] cftw);
    exp_t x;
    if (r) begin
      m_phase = '0;
      m_hold  = 0;
      m_last  = 0;
      m_q.delete();
    end else begin
      if (e) begin
        x.due = cyc + 2;
        x.val = ref_sample(m_phase);
        m_q.push_back(x);
        m_phase = m_phase + cftw + 32'(m_hold >>> DEV_SHIFT);
      end
      if (av) m_hold = aud;
    end
  endtask

  task automatic compare();
    bit ev;
    ev = (m_q.size() > 0) && (m_q[0].due == cyc);
    check("out_valid", longint'(bus.out_valid), longint'(ev));
    if (ev) begin
      m_last = m_q[0].val;
      void'(m_q.pop_front());
    end
    check("fm_out", longint'(bus.fm_out), longint'(m_last));
    check("phase_acc", longint'(dut.phase_acc), longint'(m_phase));
    if (ev && tone_on) begin
      check("tone_seq", longint'(bus.fm_out), longint'(tone[tone_idx % 4]));
      tone_idx++;
      if (tone_idx == 8) tone_on = 1'b0;
    end
  endtask

  task automatic step(input bit r, input bit e, input bit av, input int aud,
                      input bit [31:0] cftw);
    @(negedge clk);
    rst             = r;
    bus.en          = e;
    bus.audio_valid = av;
    bus.audio_in    = aud;
    bus.carrier_ftw = cftw;
    @(posedge clk);
    cyc++;
    model_edge(r, e, av, aud, cftw);
    #1;
    compare();
  endtask

  localparam bit [31:0] F30 = 32'h4000_0000;

  initial begin
    rst             = 1'b1;
    bus.en          = 1'b0;
    bus.audio_valid = 1'b0;
    bus.audio_in    = '0;
    bus.carrier_ftw = '0;

    // Reset state
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Quarter-rate tone: 25, 32767, -25, -32767
    tone_on  = 1'b1;
    tone_idx = 0;
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, F30);

    // Positive deviation pulse, captured on an en edge
    step(0, 1, 1, 32'h1000_0000, F30);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, F30);

    // Full-scale negative audio, zero carrier
    step(0, 1, 1, 32'h8000_0000, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);

    // en gaps: phase and fm_out hold
    step(0, 0, 1, 0, F30);
    for (int rep = 0; rep < 3; rep++) begin
      step(0, 1, 0, 0, F30);
      step(0, 0, 0, 0, F30);
      step(0, 0, 0, 0, F30);
      step(0, 1, 0, 0, F30);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, F30);

    // Mid-stream reset discards in-flight samples
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, F30);
    step(1, 1, 0, 0, F30);
    tone_on  = 1'b1;
    tone_idx = 0;
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, F30);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0), int'($urandom()), $urandom());
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
